// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared memory-interface types for the tagged memory responder and its
//   tag allocator.
//
//   ADDR           : 32-bit byte address
//   MEM_BLOCK      : 64-bit data block
//   MEM_TAG        : transaction tag (0 = none / rejected)
//   MEM_COMMAND    : MEM_NONE / MEM_LOAD / MEM_STORE
//   MEM_RESP_STAGE : one slot of the return pipeline {valid, tag, data}
//
//   Optional feature macro: MEM_RESP_STALL_EN (stall LFSR seed and step).
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int MEM_TAG_W = 4;

    typedef logic [31:0]          ADDR;
    typedef logic [63:0]          MEM_BLOCK;
    typedef logic [MEM_TAG_W-1:0] MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef struct packed {
        logic     valid;
        MEM_TAG   tag;
        MEM_BLOCK data;
    } MEM_RESP_STAGE;

`ifdef MEM_RESP_STALL_EN
    localparam logic [15:0] STALL_LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
`endif

endpackage

// File: rtl/mem_tag_alloc.sv
// -----------------------------------------------------------------------------
// mem_tag_alloc
//   Busy bitmap for transaction tags 1..NUM_TAGS. Offers the lowest free tag
//   (0 when none is free), marks it busy on alloc_i, clears free_tag_i on
//   free_i, and reports how many tags are busy.
//
//   clock, reset  : clock, synchronous active-high reset
//   alloc_i       : consume alloc_tag_o at this edge (only when it is nonzero)
//   free_i        : release free_tag_i at this edge
//   free_tag_i    : tag being released
//   alloc_tag_o   : lowest free tag from the registered bitmap, 0 if full
//   count_o       : number of busy tags
// -----------------------------------------------------------------------------
module mem_tag_alloc
    import mem_responder_pkg::*;
#(
    parameter  int NUM_TAGS = 15,
    localparam int CNT_W    = $clog2(NUM_TAGS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_i,
    input  logic             free_i,
    input  MEM_TAG           free_tag_i,
    output MEM_TAG           alloc_tag_o,
    output logic [CNT_W-1:0] count_o
);

    logic [NUM_TAGS:1] busy_q;
    logic [NUM_TAGS:1] busy_d;

    // Lowest free tag wins. The search reads busy_q, so a tag freed this
    // cycle only becomes visible next cycle.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        alloc_tag_o = '0;
        for (int i = NUM_TAGS; i >= 1; i--) begin
            if (!busy_q[i]) alloc_tag_o = MEM_TAG'(i);
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (free_i && free_tag_i == MEM_TAG'(i))   busy_d[i] = 1'b0;
            if (alloc_i && alloc_tag_o == MEM_TAG'(i)) busy_d[i] = 1'b1;
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            count_o = count_o + CNT_W'(busy_q[i]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Tagged memory responder. Accepts at most one MEM_LOAD/MEM_STORE per cycle,
//   answers with a nonzero transaction tag in the same cycle (0 = retry), and
//   returns {data_tag, data} exactly LATENCY cycles after acceptance. Stores
//   are acknowledged with data 0.
//
//   clock, reset             : clock, synchronous active-high reset
//   proc2mem_command         : MEM_NONE / MEM_LOAD / MEM_STORE
//   proc2mem_addr            : byte address, block index = addr[15:3] mod MEM_BLOCKS
//   proc2mem_data            : store data
//   mem2proc_transaction_tag : acceptance tag this cycle, 0 = not accepted
//   mem2proc_data            : returned block (0 for store acks / idle)
//   mem2proc_data_tag        : tag of the completing transaction, 0 = none
//   outstanding_cnt          : tags currently in flight
//
//   Optional feature macro: MEM_RESP_STALL_EN -- a free-running LFSR randomly
//   forces rejections to exercise requester retry paths.
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter  int NUM_TAGS   = 15,
    parameter  int LATENCY    = 4,
    parameter  int MEM_BLOCKS = 8192,
    localparam int CNT_W      = $clog2(NUM_TAGS + 1),
    localparam int IDX_W      = $clog2(MEM_BLOCKS)
) (
    input  logic             clock,
    input  logic             reset,
    input  MEM_COMMAND       proc2mem_command,
    input  ADDR              proc2mem_addr,
    input  MEM_BLOCK         proc2mem_data,
    output MEM_TAG           mem2proc_transaction_tag,
    output MEM_BLOCK         mem2proc_data,
    output MEM_TAG           mem2proc_data_tag,
    output logic [CNT_W-1:0] outstanding_cnt
);

    MEM_BLOCK      mem_q  [MEM_BLOCKS];
    MEM_RESP_STAGE pipe_q [LATENCY];
    MEM_RESP_STAGE stage0_d;
    MEM_RESP_STAGE ret;

    logic [IDX_W-1:0] blk_idx;
    MEM_TAG           free_tag;
    logic             is_cmd;
    logic             stall;
    logic             accept;

    assign blk_idx = IDX_W'(32'(proc2mem_addr[15:3]) % MEM_BLOCKS);

`ifdef MEM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= STALL_LFSR_SEED;
        else       lfsr_q <= lfsr16_next(lfsr_q);
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Accept only outside reset, so the tag output is 0 for the whole reset
    // cycle and resumes the first cycle after it.
    assign is_cmd = (proc2mem_command == MEM_LOAD) || (proc2mem_command == MEM_STORE);
    assign accept = !reset && is_cmd && (free_tag != '0) && !stall;

    assign mem2proc_transaction_tag = accept ? free_tag : '0;

    // Loads read the array combinationally before this edge's store lands,
    // so a load always sees the value from before any concurrent write.
    always_comb begin
        stage0_d = '0;
        if (accept) begin
            stage0_d.valid = 1'b1;
            stage0_d.tag   = free_tag;
            stage0_d.data  = (proc2mem_command == MEM_LOAD) ? mem_q[blk_idx] : '0;
        end
    end

    // Stage k is visible k+1 cycles after acceptance, so the last stage
    // presents the response exactly LATENCY cycles after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= stage0_d;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // NOTE: the backing store is deliberately not reset; contents survive
    // reset and it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (accept && proc2mem_command == MEM_STORE) mem_q[blk_idx] <= proc2mem_data;
    end

    assign ret = pipe_q[LATENCY-1];

    assign mem2proc_data_tag = (!reset && ret.valid) ? ret.tag  : '0;
    assign mem2proc_data     = (!reset && ret.valid) ? ret.data : '0;

    mem_tag_alloc #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_alloc (
        .clock       (clock),
        .reset       (reset),
        .alloc_i     (accept),
        .free_i      (ret.valid),
        .free_tag_i  (ret.tag),
        .alloc_tag_o (free_tag),
        .count_o     (outstanding_cnt)
    );

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Two responders share one clock: dut_a with LATENCY 4 and dut_b with
//   LATENCY 20 (the latter can run out of tags). The stimulus side pushes the
//   expected response of every accepted request into a per-DUT queue; a
//   monitor pops and compares whenever a DUT returns data. Build with
//   MEM_RESP_STALL_EN to run the random-stall retry test instead of the
//   directed sequences.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LAT_A = 4;
    localparam int LAT_B = 20;

    typedef struct {
        MEM_TAG   tag;
        MEM_BLOCK data;
        int       due;
    } resp_t;

    logic       clock;
    logic       reset;
    MEM_COMMAND cmd_a, cmd_b;
    ADDR        addr_a, addr_b;
    MEM_BLOCK   wdata_a, wdata_b;
    MEM_TAG     ttag_a, ttag_b, dtag_a, dtag_b;
    MEM_BLOCK   rdata_a, rdata_b;
    logic [3:0] cnt_a, cnt_b;

    resp_t      sb_a[$];
    resp_t      sb_b[$];
    MEM_BLOCK   model_a[int];
    MEM_BLOCK   model_b[int];
    logic [15:0] infl_a, infl_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    mem_responder #(.NUM_TAGS(15), .LATENCY(LAT_A), .MEM_BLOCKS(8192)) dut_a (
        .clock                    (clock),
        .reset                    (reset),
        .proc2mem_command         (cmd_a),
        .proc2mem_addr            (addr_a),
        .proc2mem_data            (wdata_a),
        .mem2proc_transaction_tag (ttag_a),
        .mem2proc_data            (rdata_a),
        .mem2proc_data_tag        (dtag_a),
        .outstanding_cnt          (cnt_a)
    );

    mem_responder #(.NUM_TAGS(15), .LATENCY(LAT_B), .MEM_BLOCKS(8192)) dut_b (
        .clock                    (clock),
        .reset                    (reset),
        .proc2mem_command         (cmd_b),
        .proc2mem_addr            (addr_b),
        .proc2mem_data            (wdata_b),
        .mem2proc_transaction_tag (ttag_b),
        .mem2proc_data            (rdata_b),
        .mem2proc_data_tag        (dtag_b),
        .outstanding_cnt          (cnt_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected response for an accepted request; stores update the model.
    task automatic record(input int which, input MEM_COMMAND c, input ADDR a,
                          input MEM_BLOCK d, input MEM_TAG tag);
        resp_t e;
        int    idx;
        idx   = int'(a[15:3]);
        e.tag = tag;
        if (which == 0) begin
            check("dup_tag_a", 64'(infl_a[tag]), 64'd0);
            infl_a[tag] = 1'b1;
            e.due  = cyc + LAT_A;
            e.data = (c == MEM_LOAD) ? model_a[idx] : '0;
            if (c == MEM_STORE) model_a[idx] = d;
            sb_a.push_back(e);
        end else begin
            check("dup_tag_b", 64'(infl_b[tag]), 64'd0);
            infl_b[tag] = 1'b1;
            e.due  = cyc + LAT_B;
            e.data = (c == MEM_LOAD) ? model_b[idx] : '0;
            if (c == MEM_STORE) model_b[idx] = d;
            sb_b.push_back(e);
        end
    endtask

    // Drive one request for a cycle and check the same-cycle tag.
    task automatic issue(input int which, input MEM_COMMAND c, input ADDR a,
                         input MEM_BLOCK d, input int exp_tag);
        MEM_TAG got;
        @(posedge clock); #1;
        cmd_a = MEM_NONE;
        cmd_b = MEM_NONE;
        if (which == 0) begin cmd_a = c; addr_a = a; wdata_a = d; end
        else            begin cmd_b = c; addr_b = a; wdata_b = d; end
        @(negedge clock);
        got = (which == 0) ? ttag_a : ttag_b;
        check((which == 0) ? "accept_tag_a" : "accept_tag_b", 64'(got), 64'(exp_tag));
        if (exp_tag != 0) record(which, c, a, d, MEM_TAG'(exp_tag));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            cmd_a = MEM_NONE;
            cmd_b = MEM_NONE;
        end
    endtask

    task automatic monitor_one(input int which, input MEM_TAG dtag, input MEM_BLOCK dat);
        resp_t e;
        int    n;
        n = (which == 0) ? sb_a.size() : sb_b.size();
        if (dtag != '0) begin
            if (n == 0) begin
                check("spurious_return", 64'(dtag), 64'd0);
            end else begin
                if (which == 0) begin e = sb_a.pop_front(); infl_a[e.tag] = 1'b0; end
                else            begin e = sb_b.pop_front(); infl_b[e.tag] = 1'b0; end
                check("ret_tag",   64'(dtag), 64'(e.tag));
                check("ret_data",  dat, e.data);
                check("ret_cycle", 64'(cyc), 64'(e.due));
            end
        end else begin
            check("idle_data", dat, 64'd0);
            if (n != 0) begin
                e = (which == 0) ? sb_a[0] : sb_b[0];
                if (cyc > e.due) begin
                    check("missing_return", 64'(dtag), 64'(e.tag));
                    if (which == 0) begin void'(sb_a.pop_front()); infl_a[e.tag] = 1'b0; end
                    else            begin void'(sb_b.pop_front()); infl_b[e.tag] = 1'b0; end
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            monitor_one(0, dtag_a, rdata_a);
            monitor_one(1, dtag_b, rdata_b);
        end
    end

    initial begin
        reset   = 1'b1;
        cmd_a   = MEM_LOAD;
        cmd_b   = MEM_NONE;
        addr_a  = 32'h0000_0040;
        addr_b  = '0;
        wdata_a = '0;
        wdata_b = '0;
        infl_a  = '0;
        infl_b  = '0;

        // Reset: a request held during reset is not accepted; state is clear.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ttag_a", 64'(ttag_a), 64'd0);
        check("reset_dtag_a", 64'(dtag_a), 64'd0);
        check("reset_data_a", rdata_a, 64'd0);
        check("reset_cnt_a",  64'(cnt_a),  64'd0);
        check("reset_cnt_b",  64'(cnt_b),  64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        cmd_a = MEM_NONE;

`ifdef MEM_RESP_STALL_EN
        begin
            int acc = 0;
            int rej = 0;
            int tries = 0;
            // Preload the block, retrying through stalls.
            do begin
                @(posedge clock); #1;
                cmd_a = MEM_STORE; addr_a = 32'h40; wdata_a = 64'hDEAD_BEEF_0000_0001;
                @(negedge clock);
                tries++;
            end while (ttag_a == '0 && tries < 64);
            check("stall_store_accepted", 64'(ttag_a != '0), 64'd1);
            if (ttag_a != '0) record(0, MEM_STORE, 32'h40, 64'hDEAD_BEEF_0000_0001, ttag_a);
            for (int k = 0; k < 1000; k++) begin
                @(posedge clock); #1;
                cmd_a = MEM_LOAD; addr_a = 32'h40;
                @(negedge clock);
                if (ttag_a != '0) begin
                    acc++;
                    check("stall_tag_range", 64'(ttag_a <= MEM_TAG'(15)), 64'd1);
                    record(0, MEM_LOAD, 32'h40, '0, ttag_a);
                end else begin
                    rej++;
                end
            end
            idle(30);
            check("stall_rejects_seen", 64'(rej > 0), 64'd1);
            check("stall_accepts_seen", 64'(acc > 0), 64'd1);
        end
`else
        // dut_a, LATENCY 4: store/load ordering, address wrap, tag reuse.
        issue(0, MEM_STORE, 32'h0000_0040, 64'hDEAD_BEEF_0000_0001, 1);
        issue(0, MEM_LOAD,  32'h0000_0040, '0, 2);
        issue(0, MEM_STORE, 32'h0000_0080, 64'h1234, 3);
        issue(0, MEM_LOAD,  32'h0000_0080, '0, 4);
        issue(0, MEM_LOAD,  32'h0001_0045, '0, 5);   // wraps onto block 8
        check("cnt_a_four_busy", 64'(cnt_a), 64'd4);
        issue(0, MEM_LOAD,  32'h0000_0080, '0, 1);   // tag 1 freed last cycle
        issue(0, MEM_LOAD,  32'h0000_0080, '0, 2);   // old value 0x1234
        issue(0, MEM_STORE, 32'h0000_0080, 64'h5678, 3);
        issue(0, MEM_LOAD,  32'h0000_0080, '0, 4);   // sees 0x5678
        idle(8);
        @(negedge clock);
        check("cnt_a_drained", 64'(cnt_a), 64'd0);

        // Reset with three loads in flight: all dropped, tags restart at 1.
        issue(0, MEM_LOAD, 32'h0000_0040, '0, 1);
        issue(0, MEM_LOAD, 32'h0000_0040, '0, 2);
        issue(0, MEM_LOAD, 32'h0000_0040, '0, 3);
        @(posedge clock); #1;
        reset = 1'b1;
        cmd_a = MEM_LOAD;
        sb_a.delete();
        infl_a = '0;
        @(negedge clock);
        check("ttag_during_reset", 64'(ttag_a), 64'd0);
        check("cnt_before_reset",  64'(cnt_a),  64'd3);
        @(posedge clock); #1;
        reset = 1'b0;
        cmd_a = MEM_NONE;
        @(negedge clock);
        check("cnt_after_reset", 64'(cnt_a), 64'd0);
        idle(8);
        issue(0, MEM_LOAD, 32'h0000_0040, '0, 1);   // memory kept across reset
        idle(6);

        // dut_b, LATENCY 20: exhaust the 15 tags, then retry until one frees.
        issue(1, MEM_STORE, 32'h0000_0100, 64'hCAFE_F00D_0000_0042, 1);
        idle(22);
        for (int k = 0; k < 15; k++) issue(1, MEM_LOAD, 32'h0000_0100, '0, k + 1);
        issue(1, MEM_LOAD, 32'h0000_0100, '0, 0);
        check("cnt_b_full", 64'(cnt_b), 64'd15);
        for (int k = 0; k < 5; k++) issue(1, MEM_LOAD, 32'h0000_0100, '0, 0);
        issue(1, MEM_LOAD, 32'h0000_0100, '0, 1);   // cycle after tag 1 returned
        idle(25);
`endif

        @(negedge clock);
        check("sb_a_drained", 64'(sb_a.size()), 64'd0);
        check("sb_b_drained", 64'(sb_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
